// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_pkg;

    // Default operand width.
    localparam int unsigned MUL_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Width of the partial-product index counter for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned MUL_CW = cnt_width(MUL_W);

endpackage

// File: rtl/mulseq.sv
// Sequential shift-add multiplier: one partial product per clock,
// unsigned or two's-complement operands, start/busy/done handshake.
module mulseq
    import mul_pkg::*;
#(
    parameter int unsigned W = MUL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   out
);

    localparam int unsigned CW = cnt_width(W);
    localparam int unsigned PW = 2 * W;

    state_t          r_state;
    logic [W-1:0]    r_mx;
    logic [W-1:0]    r_my;
    logic            r_neg;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_out;

    logic [W-1:0]    w_mx;
    logic [W-1:0]    w_my;
    logic            w_neg;
    logic [PW-1:0]   w_part;
    logic [PW-1:0]   w_res;
    logic            w_last;

    // Operand magnitudes and product sign; -2^(W-1) negates to itself,
    // which read unsigned is exactly its magnitude.
    assign w_mx  = (sgn && x[W-1]) ? (-x) : x;
    assign w_my  = (sgn && y[W-1]) ? (-y) : y;
    assign w_neg = sgn & (x[W-1] ^ y[W-1]);

    // Current partial product and final sign correction.
    assign w_part = r_my[r_cnt] ? ({{W{1'b0}}, r_mx} << r_cnt) : '0;
    assign w_res  = r_neg ? (-r_acc) : r_acc;
    assign w_last = (r_cnt == CW'(W - 1));

    // Controller, counter and accumulator; all outputs registered.
    // busy is also set on the FIN edge so it covers the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mx    <= '0;
            r_my    <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= start;
                    if (start) begin
                        r_mx    <= w_mx;
                        r_my    <= w_my;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_busy <= 1'b1;
                    r_acc  <= r_acc + w_part;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= FIN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIN: begin
                    r_busy  <= 1'b1;
                    r_done  <= 1'b1;
                    r_out   <= w_res;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_mulseq.sv
// Scoreboard bench for mulseq: stimulus pushes expected products and
// timing marks; a negedge monitor checks busy/done/out every cycle.
module tb_mulseq;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             k;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sgn;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    bit             mon_on = 1'b0;
    exp_t           sb[$];
    bit             busy_exp[int];
    bit             done_exp[int];
    logic [2*W-1:0] exp_out = '0;

    mulseq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    // Scoreboard monitor: cycle-accurate busy/done and held-product checks.
    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", 64'(busy), 64'(busy_exp.exists(cyc)));
            check("done", 64'(done), 64'(done_exp.exists(cyc)));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_out = e.prod;
                    check("latency", 64'(cyc), 64'(e.k + W + 1));
                end
            end
            check("out", 64'(out), 64'(exp_out));
        end
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit has_want, input logic [2*W-1:0] want);
        exp_t e;
        int   k;
        start = 1'b1; sgn = s; x = a; y = b;
        k = cyc + 1;
        e.prod = has_want ? want : ref_mul(s, a, b);
        e.k    = k;
        sb.push_back(e);
        for (int c = k; c <= k + W + 1; c++) busy_exp[c] = 1'b1;
        done_exp[k + W + 1] = 1'b1;
        @(negedge clk);
        start = 1'b0; sgn = 1'($urandom); x = W'($urandom); y = W'($urandom);
    endtask

    // Returns at the negedge inside the done cycle, or flags a timeout.
    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] edges [5];
        edges[0] = '0; edges[1] = W'(1); edges[2] = {1'b1, {(W-1){1'b0}}};
        edges[3] = {1'b0, {(W-1){1'b1}}}; edges[4] = '1;
        if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
        return W'($urandom);
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; x = '0; y = '0;
        idle(3);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_out",  64'(out),  64'(0));
        rst = 1'b0;
        mon_on = 1'b1;
        idle(2);

        // Directed products with fixed expected values.
        issue(1'b0, 8'd3,   8'd5,   1'b1, 16'd15);   wait_done(); idle(2);
        issue(1'b0, 8'd255, 8'd255, 1'b1, 16'hFE01); wait_done(); idle(1);
        issue(1'b1, 8'hFD,  8'd5,   1'b1, 16'hFFF1); wait_done();
        issue(1'b1, 8'h80,  8'h80,  1'b1, 16'h4000); wait_done();
        issue(1'b1, 8'h80,  8'd1,   1'b1, 16'hFF80); wait_done(); idle(2);

        // Start while busy is ignored; product then holds through idle.
        issue(1'b0, 8'd7, 8'd6, 1'b1, 16'd42);
        idle(2);
        start = 1'b1; sgn = 1'b0; x = 8'd2; y = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        idle(6);
        check("hold42", 64'(out), 64'(42));

        // Reset in mid-operation abandons it at once.
        issue(1'b0, 8'd9, 8'd9, 1'b1, 16'd81);
        idle(3);
        #1 rst = 1'b1;
        sb.delete(); busy_exp.delete(); done_exp.delete(); exp_out = '0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_out",  64'(out),  64'(0));
        idle(2);
        rst = 1'b0;
        idle(1);
        issue(1'b0, 8'd2, 8'd3, 1'b1, 16'd6); wait_done();

        // Back-to-back: next start on the edge that ends the done cycle.
        issue(1'b1, 8'd12, 8'hF6, 1'b0, '0); wait_done();
        issue(1'b0, 8'd200, 8'd3, 1'b0, '0); wait_done(); idle(1);

        // Randomized operations with random gaps (0 = back-to-back).
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), pick(), pick(), 1'b0, '0);
            wait_done();
            idle($urandom_range(2));
        end

        idle(4);
        check("drain", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
